led_bus_arbiter: RTL
====================

Name: led_bus_arbiter

Overview:
- Round-robin arbiter that shares the LED peripheral write port (wr_en / data_address / write_data) between up to 4 bus masters, e.g. the ROM-sequenced CPU and a debug/pattern master.
- Sits between the masters and the LED peripheral.
- Each master posts a single write using a req/ack handshake.
- The arbiter serialises the writes, range-checks each address, and enforces a minimum idle gap between consecutive writes.

Parameters:
- NREQ, 3, number of requesters (legal 2..4).
- AW, 8, address width.
- DW, 8, data width.
- ADDR_MIN, 1, lowest legal peripheral register address.
- ADDR_MAX, 3, highest legal peripheral register address.
- GAP_CYC, 2, idle cycles after each grant before the next grant (legal 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-master write request, level.
- req_addr  in  NREQ*AW  master i address at bits [i*AW +: AW].
- req_data  in  NREQ*DW  master i data at bits [i*DW +: DW].
- ack  out  NREQ  one-cycle pulse: request i consumed.
- err  out  NREQ  one-cycle pulse, coincident with ack[i]: address out of range, write dropped.
- wr_en  out  1  peripheral write strobe, one cycle.
- data_address  out  AW  peripheral address.
- write_data  out  DW  peripheral write data.
- grant_id  out  2  index of the last granted master.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst low, asynchronous, any state):
  - ack, err, wr_en, data_address, write_data, grant_id all 0.
  - busy 0, state IDLE, rr_ptr 0, gap_cnt 0.
  - An in-flight write is abandoned; no write strobe appears after reset is released.
- All outputs are registered.
- FSM states: IDLE, WRITE, GAP.
- IDLE:
  - If any req is high at a rising edge, the winner w is the first i with req[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo NREQ.
  - At that edge:
    - ack[w]<=1, grant_id<=w, rr_ptr<=(w+1) mod NREQ, state<=WRITE.
    - data_address<=req_addr[w], write_data<=req_data[w].
    - If ADDR_MIN <= addr <= ADDR_MAX: wr_en<=1.
    - Otherwise: err[w]<=1, wr_en stays 0.
  - Latency: req sampled at edge E0; ack, err and wr_en are visible in the cycle after E0, all together.
  - No req high: stay in IDLE, outputs unchanged.
- WRITE (exactly one cycle):
  - At the next edge: ack, err and wr_en <= 0; gap_cnt<=GAP_CYC-1; state<=GAP.
- GAP:
  - All requests are ignored.
  - gap_cnt==0: state<=IDLE.
  - Otherwise: gap_cnt decrements.
  - A master sees ack at edge E1 and must drop req (or present a new request) by the end of the GAP window. The GAP state guarantees the same request is never granted twice.
- Held outputs:
  - data_address and write_data keep their last values between writes, including after an err grant.
  - grant_id holds until the next grant.
- Masters must keep req_addr and req_data stable while req is high and ack has not yet been seen.
- Throughput: one grant per 2+GAP_CYC cycles (4 cycles at the defaults).
- Fairness: a continuously requesting master waits at most NREQ-1 grants.
- Simultaneous requests: resolved only by rr_ptr; there is no fixed priority.
- Request dropped before it is granted: no ack, no side effects.
- req bits at index >= NREQ do not exist; grant_id upper bits are 0 when NREQ <= 2.

Test Plan:
- Reset, then req[0]=1, addr=1, data=0x05 → one cycle later: ack[0]=1, wr_en=1, data_address=1, write_data=0x05, grant_id=0. Next cycle: wr_en=0, busy=1 for 2 cycles, then IDLE.
- req[0..2] all high from reset, rr_ptr=0, each master dropping req on its own ack → grants in order 0,1,2, with wr_en pulses exactly 4 cycles apart.
- Master 1 holds req high continuously; master 0 requests once, after the first grant to 1 → order is 1,0,1,1,... Master 0 waits no more than one grant.
- req[2]=1 with addr=0x07 → ack[2]=1 and err[2]=1 in the same cycle, wr_en stays 0, data_address=0x07. The next legal request proceeds normally.
- rst driven low in the WRITE cycle → wr_en, ack and busy go to 0 immediately (asynchronously). After release with no req pending, there is no wr_en pulse.
- Master 0 raises req during GAP → no ack until state returns to IDLE; ack appears exactly one cycle after the first IDLE edge.

Source files
------------

// File: rtl/led_bus_arbiter.sv
// rtl/led_bus_arbiter.sv - round-robin arbiter sharing the LED peripheral write port
// Serialises single-write requests, range-checks addresses and enforces an idle gap.
module led_bus_arbiter #(
  parameter int NREQ     = 3,
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int ADDR_MIN = 1,
  parameter int ADDR_MAX = 3,
  parameter int GAP_CYC  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    err,
  output logic               wr_en,
  output logic [AW-1:0]      data_address,
  output logic [DW-1:0]      write_data,
  output logic [1:0]         grant_id,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic [1:0]        grant_q, grant_d;

  logic              found;
  logic [1:0]        win;
  logic [2:0]        cand;
  logic [AW-1:0]     sel_addr;
  logic              in_range;

  // Rotating search starting at rr_ptr; the first requester found wins.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    cand  = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + 3'(k);
      if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
      if (!found && req[cand[1:0]]) begin
        found = 1'b1;
        win   = cand[1:0];
      end
    end
  end

  assign sel_addr = req_addr[int'(win)*AW +: AW];
  assign in_range = (sel_addr >= AW'(ADDR_MIN)) && (sel_addr <= AW'(ADDR_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= 2'd0;
      gap_cnt_q <= 4'd0;
      ack_q     <= '0;
      err_q     <= '0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      grant_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gap_cnt_q <= gap_cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      grant_q   <= grant_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_WRITE;
          rr_ptr_d = (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
        end
      end
      S_WRITE: begin
        state_d   = S_GAP;
        gap_cnt_d = 4'(GAP_CYC - 1);
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) state_d = S_IDLE;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes default low so WRITE and GAP clear them; address/data/grant hold.
  always_comb begin
    ack_d   = '0;
    err_d   = '0;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    grant_d = grant_q;
    if (state_q == S_IDLE && found) begin
      ack_d[win] = 1'b1;
      grant_d    = win;
      addr_d     = sel_addr;
      data_d     = req_data[int'(win)*DW +: DW];
      if (in_range) wr_en_d    = 1'b1;
      else          err_d[win] = 1'b1;
    end
  end

  assign ack          = ack_q;
  assign err          = err_q;
  assign wr_en        = wr_en_q;
  assign data_address = addr_q;
  assign write_data   = data_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q != S_IDLE);

endmodule
